// File: rtl/fractionned_divider.sv
// Purpose : iterative 32-bit restoring divider (quotient + remainder), one quotient bit per clock.
// Latency : output_valid high after the 34th edge following the first edge that samples enable high.
// Backpr. : enable is a level request; dropping it aborts, and in DONE it releases the result.
//
// Ports:
//   clock, reset_n        single clock, asynchronous active-low reset
//   input_a / input_b     dividend / divisor, sampled only in LOAD
//   signed_a / signed_b   per-operand two's-complement select (FRAC_DIV_SIGNED_EN builds only)
//   enable                request, held high for the whole operation
//   output_quotient       quotient, updated only in FIX
//   output_remainder      remainder, updated only in FIX
//   output_valid          high in DONE until enable drops
//
// Optional feature macro: FRAC_DIV_SIGNED_EN enables signed operand handling.
// Without it, signed_a/signed_b are ignored and every operand is unsigned.

module fractionned_divider (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    input  logic        signed_a,
    input  logic        signed_b,
    input  logic        enable,
    output logic [31:0] output_quotient,
    output logic [31:0] output_remainder,
    output logic        output_valid
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        load_en;
    logic        iter_en;
    logic        fix_en;

    // {remainder, quotient}: the dividend shifts up out of the low half
    // while quotient bits fill in behind it.
    logic [63:0] acc;
    logic [31:0] dvsr;
    logic [4:0]  iter_cnt;

    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] trial_hi;
    logic [33:0] trial_diff;
    logic        no_borrow;
    logic [63:0] acc_shifted;
    logic        unused_diff_bit;

    logic [31:0] quo_final;
    logic [31:0] rem_final;

`ifdef FRAC_DIV_SIGNED_EN
    logic        a_neg;
    logic        b_neg;
    logic        quo_neg;
    logic        rem_neg;
    logic        div_zero;
`else
    logic        unused_sign_sel;
    assign unused_sign_sel = signed_a ^ signed_b;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Any loss of enable before DONE abandons the divide.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (enable) state_nxt = S_LOAD;
            S_LOAD: state_nxt = enable ? S_ITER : S_IDLE;
            S_ITER: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (iter_cnt == 5'd31) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:  state_nxt = enable ? S_DONE : S_IDLE;
            S_DONE: if (!enable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        load_en      = (state == S_LOAD) && enable;
        iter_en      = (state == S_ITER) && enable;
        fix_en       = (state == S_FIX)  && enable;
        output_valid = (state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
`ifdef FRAC_DIV_SIGNED_EN
    always_comb begin
        a_neg = signed_a & input_a[31];
        b_neg = signed_b & input_b[31];
        // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
        a_mag = a_neg ? (32'd0 - input_a) : input_a;
        b_mag = b_neg ? (32'd0 - input_b) : input_b;
    end
`else
    always_comb begin
        a_mag = input_a;
        b_mag = input_b;
    end
`endif

    // ------------------------------------------------------------------
    // One restoring step. The partial remainder is always below the
    // divisor, so after a successful subtract it fits back in 32 bits.
    // ------------------------------------------------------------------
    always_comb begin
        trial_hi        = acc[63:31];
        trial_diff      = {1'b0, trial_hi} - {2'b00, dvsr};
        no_borrow       = ~trial_diff[33];
        unused_diff_bit = trial_diff[32];
        if (no_borrow) begin
            acc_shifted = {trial_diff[31:0], acc[30:0], 1'b1};
        end else begin
            acc_shifted = {acc[62:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Final sign correction. A zero divisor leaves the all-ones quotient
    // unsigned, and the remainder comes back as the original dividend.
    // ------------------------------------------------------------------
`ifdef FRAC_DIV_SIGNED_EN
    always_comb begin
        quo_final = (quo_neg && !div_zero) ? (32'd0 - acc[31:0]) : acc[31:0];
        rem_final = rem_neg ? (32'd0 - acc[63:32]) : acc[63:32];
    end
`else
    always_comb begin
        quo_final = acc[31:0];
        rem_final = acc[63:32];
    end
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= 64'd0;
            dvsr     <= 32'd0;
            iter_cnt <= 5'd0;
        end else if (load_en) begin
            acc      <= {32'd0, a_mag};
            dvsr     <= b_mag;
            iter_cnt <= 5'd0;
        end else if (iter_en) begin
            acc      <= acc_shifted;
            iter_cnt <= iter_cnt + 5'd1;
        end
    end

`ifdef FRAC_DIV_SIGNED_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
        end else if (load_en) begin
            quo_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            div_zero <= (input_b == 32'd0);
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            output_quotient  <= 32'd0;
            output_remainder <= 32'd0;
        end else if (fix_en) begin
            output_quotient  <= quo_final;
            output_remainder <= rem_final;
        end
    end

endmodule

// File: tb/tb_fractionned_divider.sv
module tb_fractionned_divider;

    logic        clock;
    logic        reset_n;
    logic [31:0] input_a;
    logic [31:0] input_b;
    logic        signed_a;
    logic        signed_b;
    logic        enable;
    logic [31:0] output_quotient;
    logic [31:0] output_remainder;
    logic        output_valid;

    int checks = 0;
    int errors = 0;

    fractionned_divider dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .input_a          (input_a),
        .input_b          (input_b),
        .signed_a         (signed_a),
        .signed_b         (signed_b),
        .enable           (enable),
        .output_quotient  (output_quotient),
        .output_remainder (output_remainder),
        .output_valid     (output_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Arithmetic reference for one division.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic sa, input logic sb,
                                    output logic [31:0] q, output logic [31:0] r);
        longint la;
        longint lb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            return;
        end
`ifdef FRAC_DIV_SIGNED_EN
        la = sa ? longint'($signed(a)) : longint'(a);
        lb = sb ? longint'($signed(b)) : longint'(b);
`else
        la = longint'(a);
        lb = longint'(b);
`endif
        lq = la / lb;
        lr = la % lb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Transaction-level model: count consecutive cycles of enable high from
    // idle; operands are taken on the 2nd such edge, the result lands on the 35th.
    logic        m_valid;
    logic [31:0] m_q;
    logic [31:0] m_r;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        m_sa;
    logic        m_sb;
    int          run;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_valid = 1'b0;
            m_q     = 32'd0;
            m_r     = 32'd0;
            run     = 0;
        end else if (m_valid) begin
            if (!enable) begin
                m_valid = 1'b0;
                run     = 0;
            end
        end else if (!enable) begin
            run = 0;
        end else begin
            run++;
            if (run == 2) begin
                m_a  = input_a;
                m_b  = input_b;
                m_sa = signed_a;
                m_sb = signed_b;
            end
            if (run == 35) begin
                ref_div(m_a, m_b, m_sa, m_sb, m_q, m_r);
                m_valid = 1'b1;
                run     = 0;
            end
        end
    end

    always @(negedge clock) begin
        checks++;
        if (output_valid !== m_valid || output_quotient !== m_q || output_remainder !== m_r) begin
            errors++;
            $display("FAIL model_cmp t=%0t got valid=%b q=%h r=%h, want valid=%b q=%h r=%h",
                     $time, output_valid, output_quotient, output_remainder, m_valid, m_q, m_r);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Full operation with hand-computed expectations and exact latency checks.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb,
                          input logic [31:0] eq, input logic [31:0] er);
        @(posedge clock); #1;
        input_a  = a;
        input_b  = b;
        signed_a = sa;
        signed_b = sb;
        enable   = 1'b1;
        repeat (34) @(posedge clock);
        #1;
        chk({name, "_valid_e33"}, {31'd0, output_valid}, 32'd0);
        // Operand changes after LOAD must not matter.
        input_a = 32'h1357_9BDF;
        input_b = 32'h0000_0003;
        @(posedge clock); #1;
        chk({name, "_valid_e34"}, {31'd0, output_valid}, 32'd1);
        chk({name, "_quo"}, output_quotient, eq);
        chk({name, "_rem"}, output_remainder, er);
        enable = 1'b0;
        @(posedge clock); #1;
        chk({name, "_valid_off"}, {31'd0, output_valid}, 32'd0);
        chk({name, "_quo_hold"}, output_quotient, eq);
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        input_a  = 32'd0;
        input_b  = 32'd0;
        signed_a = 1'b0;
        signed_b = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", {31'd0, output_valid}, 32'd0);
        chk("rst_quo", output_quotient, 32'd0);
        chk("rst_rem", output_remainder, 32'd0);
        reset_n = 1'b1;

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2);
`ifdef FRAC_DIV_SIGNED_EN
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000, 32'h0);
        run_op("mixed", 32'hFFFF_FFF0, 32'd3, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
`else
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 1'b1, 32'h7FFF_FFFC, 32'h1);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0, 32'h8000_0000);
        run_op("mixed", 32'hFFFF_FFF0, 32'd3, 1'b1, 1'b0, 32'h5555_5550, 32'h0);
`endif
        run_op("s_div0", 32'h8765_4321, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321);
        run_op("u_div0", 32'd5, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd5);
        run_op("u_small", 32'd3, 32'd10, 1'b0, 1'b0, 32'd0, 32'd3);
        run_op("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h8000_0000);

        // Abort at iteration 10: E..E+10 pass, enable is low for edge E+11.
        @(posedge clock); #1;
        input_a  = 32'h1234_5678;
        input_b  = 32'd9;
        signed_a = 1'b0;
        signed_b = 1'b0;
        enable   = 1'b1;
        repeat (11) @(posedge clock);
        #1;
        enable = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_valid", {31'd0, output_valid}, 32'd0);
        chk("abort_quo", output_quotient, 32'h0);
        chk("abort_rem", output_remainder, 32'h8000_0000);
        run_op("after_abort", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 32'h0FFF_FFFF, 32'hF);

        // Asynchronous reset between edges, mid-ITER.
        @(posedge clock); #1;
        input_a = 32'd100;
        input_b = 32'd7;
        enable  = 1'b1;
        repeat (15) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, output_valid}, 32'd0);
        chk("arst_quo", output_quotient, 32'd0);
        chk("arst_rem", output_remainder, 32'd0);
        enable = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_op("after_rst", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2);

        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
